// File: rtl/nano4k_flash_sequencer.sv
// Request-level sequencer for the nano4k_spi_flash engine: expands READ/PROGRAM/ERASE_PAGE/READ_STATUS
// into WREN, the operation and RDSR polling, with one valid/ready port and a done/err pulse.
module nano4k_flash_sequencer #(
    parameter logic [7:0]  OP_WREN    = 8'h06,
    parameter logic [7:0]  OP_RDSR    = 8'h05,
    parameter logic [7:0]  OP_PP      = 8'h02,
    parameter logic [7:0]  OP_PE      = 8'h81,
    parameter logic [7:0]  OP_FREAD   = 8'h0B,
    parameter int          CMD_CYCLES = 16,
    parameter int          GAP_CYCLES = 8,
    parameter logic [19:0] POLL_LIMIT = 20'hFFFFF
) (
    input  logic        interfaceClk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [21:0] req_addr,
    input  logic [8:0]  req_len,
    input  logic [7:0]  wr_data,
    output logic        wr_strobe,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic [7:0]  status_out,
    output logic        done,
    output logic        err,
    output logic        fEnable_n,
    output logic [7:0]  fCommand,
    output logic [21:0] fAddress,
    output logic [7:0]  fData_WR,
    input  logic [7:0]  fData_RD,
    input  logic        RdDataValid,
    input  logic        WrDataReady
);

    typedef enum logic [2:0] {IDLE, WREN, GAP_A, OP, GAP_B, POLL, POLL_GAP, FIN} seqState_e;
    typedef enum logic [1:0] {REQ_READ, REQ_PROGRAM, REQ_ERASE, REQ_STATUS} reqOp_e;

    localparam logic [15:0] CMD_LAST   = 16'(CMD_CYCLES - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] ERASE_LAST = 16'(CMD_CYCLES + 32 - 1);

    seqState_e   state, stateNext;
    reqOp_e      opReg;
    logic [21:0] addrReg;
    logic [8:0]  lenReg;
    logic [8:0]  byteCnt;
    logic [19:0] pollCnt;
    logic [15:0] cycCnt;
    logic        errFlag;
    logic        readyReg;

    logic        accept, lenBad, lastByte, timeout, loadCmd;
    logic [7:0]  cmdNext;
    logic [21:0] addrNext;

    assign accept    = req_valid && readyReg && (state == IDLE);
    assign lenBad    = ((req_op == REQ_READ) || (req_op == REQ_PROGRAM)) &&
                       ((req_len == 9'd0) || (req_len > 9'd256));
    assign lastByte  = (byteCnt + 9'd1) == lenReg;

    assign req_ready = readyReg;
    assign done      = (state == FIN);
    assign err       = (state == FIN) && errFlag;
    assign wr_strobe = (state == OP) && (opReg == REQ_PROGRAM) && WrDataReady;
    assign fData_WR  = wr_data;

    always_ff @(posedge interfaceClk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        stateNext = state;
        loadCmd   = 1'b0;
        cmdNext   = fCommand;
        addrNext  = fAddress;
        timeout   = 1'b0;
        unique case (state)
            IDLE: if (accept) begin
                loadCmd  = !lenBad;
                addrNext = req_addr;
                if (lenBad) begin
                    stateNext = FIN;
                end else begin
                    unique case (reqOp_e'(req_op))
                        REQ_READ:   begin stateNext = OP;   cmdNext = OP_FREAD; end
                        REQ_STATUS: begin stateNext = OP;   cmdNext = OP_RDSR;  end
                        default:    begin stateNext = WREN; cmdNext = OP_WREN;  end
                    endcase
                end
            end
            WREN:  if (cycCnt == CMD_LAST) stateNext = GAP_A;
            GAP_A: if (cycCnt == GAP_LAST) begin
                stateNext = OP;
                loadCmd   = 1'b1;
                cmdNext   = (opReg == REQ_PROGRAM) ? OP_PP : OP_PE;
                addrNext  = addrReg;
            end
            OP: begin
                unique case (opReg)
                    REQ_READ:    if (RdDataValid && lastByte) stateNext = GAP_B;
                    REQ_PROGRAM: if (WrDataReady && lastByte) stateNext = GAP_B;
                    REQ_ERASE:   if (WrDataReady || (cycCnt == ERASE_LAST)) stateNext = GAP_B;
                    default:     if (RdDataValid) stateNext = GAP_B;
                endcase
            end
            GAP_B: if (cycCnt == GAP_LAST) begin
                if ((opReg == REQ_READ) || (opReg == REQ_STATUS)) begin
                    stateNext = FIN;
                end else begin
                    stateNext = POLL;
                    loadCmd   = 1'b1;
                    cmdNext   = OP_RDSR;
                end
            end
            POLL: if (RdDataValid) stateNext = POLL_GAP;
            // The full gap is always served, so a new command never follows a poll too closely.
            POLL_GAP: if (cycCnt == GAP_LAST) begin
                if (!status_out[0]) begin
                    stateNext = FIN;
                end else if (pollCnt == POLL_LIMIT) begin
                    stateNext = FIN;
                    timeout   = 1'b1;
                end else begin
                    stateNext = POLL;
                    loadCmd   = 1'b1;
                    cmdNext   = OP_RDSR;
                end
            end
            FIN:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge interfaceClk or negedge reset) begin
        if (!reset) begin
            readyReg   <= 1'b0;
            fEnable_n  <= 1'b1;
            fCommand   <= 8'h00;
            fAddress   <= 22'h0;
            status_out <= 8'h00;
            rd_data    <= 8'h00;
            rd_valid   <= 1'b0;
            opReg      <= REQ_READ;
            addrReg    <= 22'h0;
            lenReg     <= 9'h0;
            byteCnt    <= 9'h0;
            pollCnt    <= 20'h0;
            cycCnt     <= 16'h0;
            errFlag    <= 1'b0;
        end else begin
            readyReg  <= (stateNext == IDLE);
            fEnable_n <= !(stateNext inside {WREN, OP, POLL});
            cycCnt    <= (stateNext != state) ? 16'h0 : cycCnt + 16'h1;
            rd_valid  <= 1'b0;
            if (loadCmd) begin
                fCommand <= cmdNext;
                fAddress <= addrNext;
            end
            if (accept) begin
                opReg   <= reqOp_e'(req_op);
                addrReg <= req_addr;
                lenReg  <= req_len;
                byteCnt <= 9'h0;
                pollCnt <= 20'h0;
                errFlag <= lenBad;
            end
            if (timeout) errFlag <= 1'b1;
            if (state == OP) begin
                if ((opReg == REQ_READ) && RdDataValid) begin
                    byteCnt  <= byteCnt + 9'd1;
                    rd_data  <= fData_RD;
                    rd_valid <= 1'b1;
                end
                if ((opReg == REQ_PROGRAM) && WrDataReady) byteCnt <= byteCnt + 9'd1;
                if ((opReg == REQ_STATUS) && RdDataValid) status_out <= fData_RD;
            end
            if ((state == POLL) && RdDataValid) begin
                status_out <= fData_RD;
                pollCnt    <= pollCnt + 20'd1;
            end
        end
    end

endmodule

// File: tb/tb_nano4k_flash_sequencer.sv
// Directed bench for nano4k_flash_sequencer with a cycle-based flash-engine responder and
// monitors that log frames, read bytes and program strobes for the checks in the main sequence.
module tb_nano4k_flash_sequencer;

    logic        interfaceClk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [21:0] req_addr;
    logic [8:0]  req_len;
    logic [7:0]  wr_data;
    logic        wr_strobe;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [7:0]  status_out;
    logic        done;
    logic        err;
    logic        fEnable_n;
    logic [7:0]  fCommand;
    logic [21:0] fAddress;
    logic [7:0]  fData_WR;
    logic [7:0]  fData_RD = 8'h00;
    logic        RdDataValid = 1'b0;
    logic        WrDataReady = 1'b0;

    always #5 interfaceClk = ~interfaceClk;

    nano4k_flash_sequencer #(.POLL_LIMIT(20'd4)) dut (
        .interfaceClk(interfaceClk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_strobe(wr_strobe),
        .rd_data(rd_data), .rd_valid(rd_valid), .status_out(status_out),
        .done(done), .err(err),
        .fEnable_n(fEnable_n), .fCommand(fCommand), .fAddress(fAddress),
        .fData_WR(fData_WR), .fData_RD(fData_RD),
        .RdDataValid(RdDataValid), .WrDataReady(WrDataReady)
    );

    int total = 0;
    int bad   = 0;

    // Engine configuration, written only by the main sequence.
    logic stuck     = 1'b0;
    int   busyUntil = 0;
    int   wrBase    = 0;
    int   rdBase    = 0;

    logic [7:0] readBytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] progData  [4] = '{8'h5A, 8'h5B, 8'h5C, 8'h5D};

    // Flash engine model: strobes relative to the falling edge of fEnable_n.
    int engCyc    = 0;
    int rdsrSeen  = 0;
    always @(negedge interfaceClk) begin
        RdDataValid = 1'b0;
        WrDataReady = 1'b0;
        if (fEnable_n !== 1'b0) begin
            engCyc = 0;
        end else begin
            engCyc++;
            case (fCommand)
                8'h0B: if (engCyc >= 4 && engCyc <= 10 && engCyc % 2 == 0) begin
                    RdDataValid = 1'b1;
                    fData_RD    = readBytes[(engCyc - 4) / 2];
                end
                8'h05: if (engCyc == 4) begin
                    RdDataValid = 1'b1;
                    fData_RD    = (stuck || rdsrSeen < busyUntil) ? 8'h03 : 8'h00;
                    rdsrSeen++;
                end
                8'h02: if (engCyc >= 6 && engCyc % 2 == 0) WrDataReady = 1'b1;
                8'h81: if (engCyc == 10) WrDataReady = 1'b1;
                default: ;
            endcase
        end
    end

    // Program-data monitor: the next byte is presented once the current one is consumed.
    int         strobeTotal = 0;
    logic [7:0] wrCap [8];
    assign wr_data = progData[(strobeTotal - wrBase) % 4];
    always @(negedge interfaceClk) begin
        #2;
        if (wr_strobe === 1'b1) begin
            if (strobeTotal - wrBase < 8) wrCap[strobeTotal - wrBase] = fData_WR;
            strobeTotal++;
        end
    end

    int         rdTotal = 0;
    logic [7:0] rdCap [8];
    always @(negedge interfaceClk) begin
        if (rd_valid === 1'b1) begin
            if (rdTotal - rdBase < 8) rdCap[rdTotal - rdBase] = rd_data;
            rdTotal++;
        end
    end

    // Frame monitor: command/address/length of each low period, minimum high gap, stability.
    int          frameTotal = 0;
    logic [7:0]  frameCmd  [64];
    logic [21:0] frameAddr [64];
    int          frameLen  [64];
    int          highRun  = 1000;
    int          lowRun   = 0;
    int          minGap   = 1000;
    int          unstable = 0;
    logic        enPrev   = 1'b1;
    always @(negedge interfaceClk) begin
        if (fEnable_n === 1'b0) begin
            if (enPrev === 1'b1) begin
                if (frameTotal < 64) begin
                    frameCmd[frameTotal]  = fCommand;
                    frameAddr[frameTotal] = fAddress;
                end
                if (highRun < minGap) minGap = highRun;
                frameTotal++;
                lowRun = 0;
            end else if (frameTotal <= 64 &&
                         (fCommand !== frameCmd[frameTotal-1] || fAddress !== frameAddr[frameTotal-1])) begin
                unstable++;
            end
            lowRun++;
            highRun = 0;
        end else begin
            if (enPrev === 1'b0 && frameTotal <= 64) frameLen[frameTotal-1] = lowRun;
            highRun++;
        end
        enPrev = fEnable_n;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic sendReq(input logic [1:0] op, input logic [21:0] addr, input logic [8:0] len);
        req_op    = op;
        req_addr  = addr;
        req_len   = len;
        req_valid = 1'b1;
        @(negedge interfaceClk);
        req_valid = 1'b0;
    endtask

    task automatic waitDone(input int limit, output logic seen, output logic errSeen);
        seen    = 1'b0;
        errSeen = 1'bx;
        for (int i = 0; i < limit && !seen; i++) begin
            if (done === 1'b1) begin
                seen    = 1'b1;
                errSeen = err;
            end else begin
                @(negedge interfaceClk);
            end
        end
    endtask

    initial begin
        logic seen, errSeen;
        int   f0, s0, n;
        logic [8:0] badLens [3] = '{9'd0, 9'd257, 9'd0};
        logic [1:0] badOps  [3] = '{2'b00, 2'b00, 2'b01};

        reset = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_addr = 22'h0; req_len = 9'h0;
        repeat (3) @(negedge interfaceClk);
        check("rst_fEnable_n", fEnable_n, 1);
        check("rst_fCommand", fCommand, 0);
        check("rst_fAddress", fAddress, 0);
        check("rst_status", status_out, 0);
        check("rst_ready", req_ready, 0);
        check("rst_done_err", {done, err, rd_valid, wr_strobe}, 0);
        reset = 1'b1;
        @(negedge interfaceClk);
        check("ready_after_reset", req_ready, 1);

        // READ_STATUS: one RDSR frame, status 00.
        f0 = frameTotal;
        sendReq(2'b11, 22'h0, 9'd0);
        waitDone(200, seen, errSeen);
        check("rs_done", seen, 1);
        check("rs_err", errSeen, 0);
        check("rs_status", status_out, 8'h00);
        check("rs_ready_during_done", req_ready, 0);
        @(negedge interfaceClk);
        check("rs_ready_back", req_ready, 1);
        check("rs_frames", frameTotal - f0, 1);
        check("rs_cmd", frameCmd[f0], 8'h05);
        check("rs_len", frameLen[f0], 4);

        // READ 4 bytes.
        f0 = frameTotal; rdBase = rdTotal;
        sendReq(2'b00, 22'h00A001, 9'd4);
        waitDone(300, seen, errSeen);
        check("rd_done", seen, 1);
        check("rd_err", errSeen, 0);
        check("rd_count", rdTotal - rdBase, 4);
        check("rd_bytes", {rdCap[0], rdCap[1], rdCap[2], rdCap[3]}, 32'h11223344);
        check("rd_frames", frameTotal - f0, 1);
        check("rd_cmd", frameCmd[f0], 8'h0B);
        check("rd_addr", frameAddr[f0], 22'h00A001);
        check("rd_len_after_4th", frameLen[f0], 10);
        @(negedge interfaceClk);

        // PROGRAM 3 bytes, WIP busy for 3 polls.
        f0 = frameTotal; s0 = strobeTotal; wrBase = strobeTotal; busyUntil = rdsrSeen + 3;
        sendReq(2'b01, 22'h00A001, 9'd3);
        waitDone(600, seen, errSeen);
        check("pp_done", seen, 1);
        check("pp_err", errSeen, 0);
        check("pp_strobes", strobeTotal - s0, 3);
        check("pp_bytes", {8'h00, wrCap[0], wrCap[1], wrCap[2]}, 32'h005A5B5C);
        check("pp_frames", frameTotal - f0, 6);
        check("pp_cmd_wren", frameCmd[f0], 8'h06);
        check("pp_wren_len", frameLen[f0], 16);
        check("pp_cmd_pp", frameCmd[f0+1], 8'h02);
        check("pp_addr", frameAddr[f0+1], 22'h00A001);
        check("pp_len", frameLen[f0+1], 10);
        n = 0;
        for (int i = 2; i < 6; i++) if (frameCmd[f0+i] == 8'h05) n++;
        check("pp_rdsr_frames", n, 4);
        @(negedge interfaceClk);

        // ERASE_PAGE with WIP stuck: poll limit of 4 gives a timeout.
        f0 = frameTotal; s0 = strobeTotal; stuck = 1'b1;
        sendReq(2'b10, 22'h000300, 9'd0);
        waitDone(800, seen, errSeen);
        check("pe_done", seen, 1);
        check("pe_err", errSeen, 1);
        check("pe_status_wip", status_out[0], 1);
        check("pe_frames", frameTotal - f0, 6);
        check("pe_cmd", frameCmd[f0+1], 8'h81);
        check("pe_addr", frameAddr[f0+1], 22'h000300);
        check("pe_len", frameLen[f0+1], 10);
        check("pe_no_wr_strobe", strobeTotal - s0, 0);
        n = 0;
        for (int i = 2; i < 6; i++) if (frameCmd[f0+i] == 8'h05) n++;
        check("pe_polls", n, 4);
        stuck = 1'b0;
        @(negedge interfaceClk);

        // Bad lengths: immediate error, flash untouched.
        for (int k = 0; k < 3; k++) begin
            f0 = frameTotal;
            check("len_ready", req_ready, 1);
            sendReq(badOps[k], 22'h000010, badLens[k]);
            check("len_done", done, 1);
            check("len_err", err, 1);
            check("len_fen", fEnable_n, 1);
            @(negedge interfaceClk);
            check("len_done_pulse", done, 0);
            check("len_ready_back", req_ready, 1);
            check("len_no_frame", frameTotal - f0, 0);
        end

        check("gap_min", (minGap >= 8) ? 1 : 0, 1);
        check("cmd_addr_stable", unstable, 0);

        // Reset during the PP data phase.
        s0 = strobeTotal; wrBase = strobeTotal;
        sendReq(2'b01, 22'h000000, 9'd100);
        for (int i = 0; i < 300 && (strobeTotal - s0) < 2; i++) @(negedge interfaceClk);
        check("mid_pp_reached", (strobeTotal - s0 >= 2) ? 1 : 0, 1);
        check("mid_pp_fen_low", fEnable_n, 0);
        #2 reset = 1'b0;
        #1;
        check("async_rst_fen", fEnable_n, 1);
        check("async_rst_cmd", fCommand, 0);
        check("async_rst_ready", req_ready, 0);
        @(negedge interfaceClk);
        reset = 1'b1;
        @(negedge interfaceClk);
        check("post_rst_ready", req_ready, 1);
        sendReq(2'b11, 22'h0, 9'd0);
        waitDone(200, seen, errSeen);
        check("post_rst_rs_done", seen, 1);
        check("post_rst_rs_err", errSeen, 0);
        check("post_rst_rs_status", status_out, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
